// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the sequential one-bit-per-cycle shifter.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT   = 1'b1;
  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic FILL_ARITH = 1'b1;
  localparam logic FILL_LOGIC = 1'b0;

endpackage

// File: rtl/mux21.sv
// Single-bit 2:1 multiplexer primitive shared with the barrel shifter.
module mux21 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/shift1.sv
// Combinational one-position shifter: left with zero fill, or right with
// zero/sign fill, built bitwise from mux21 to mirror the barrel shifter.
module shift1
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             LR,
  input  logic             AL,
  output logic [WIDTH-1:0] shifted
);

  logic             fill;
  logic             sel_left;
  logic             sel_arith;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;

  assign sel_left  = (LR == DIR_LEFT);
  assign sel_arith = (AL == FILL_ARITH);

  mux21 u_fill (
    .d0  (1'b0),
    .d1  (data[WIDTH-1]),
    .sel (sel_arith),
    .y   (fill)
  );

  assign shl = {data[WIDTH-2:0], 1'b0};
  assign shr = {fill, data[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux21 u_bit (
      .d0  (shr[i]),
      .d1  (shl[i]),
      .sel (sel_left),
      .y   (shifted[i])
    );
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: accepts one request, shifts one position per clock,
// and holds the result until the consumer takes it.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             LR,
  input  logic             AL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_sh;
  logic [SHW-1:0]   cnt_q;
  logic             lr_q;
  logic             al_q;
  logic             accept;

  shift1 #(.WIDTH(WIDTH)) u_shift1 (
    .data    (data_q),
    .LR      (lr_q),
    .AL      (al_q),
    .shifted (data_sh)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = data_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are latched only at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      lr_q    <= DIR_RIGHT;
      al_q    <= FILL_LOGIC;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= din;
        cnt_q  <= shamt;
        lr_q   <= LR;
        al_q   <= AL;
      end else if (state_q == SHIFT) begin
        data_q <= data_sh;
        cnt_q  <= cnt_q - SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: directed cases from the shift rules plus
// randomized traffic against a plain-arithmetic shift reference.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] din = '0;
  logic [SHW-1:0]   shamt = '0;
  logic             LR = 1'b0;
  logic             AL = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] dout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc = 0;

  typedef struct {
    logic [WIDTH-1:0] val;
    int               due;
  } exp_t;

  exp_t sb[$];
  bit   showing = 1'b0;

  seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .LR        (LR),
    .AL        (AL),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] ref_shift(logic [WIDTH-1:0] d, int n, logic lr, logic al);
    logic signed [WIDTH-1:0] s;
    s = d;
    if (lr) return d << n;
    if (al) return s >>> n;
    return d >> n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue side: record the expected result and due cycle at each acceptance.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back('{ref_shift(din, int'(shamt), LR, AL), cyc + int'(shamt) + 1});
      n_acc++;
    end
  end

  // Monitor: latency on first presentation, data and in_ready on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!showing) begin
          check("latency", cyc, sb[0].due);
          showing = 1'b1;
        end
        if (out_ready) begin
          check("dout", 32'(dout), 32'(sb[0].val));
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          void'(sb.pop_front());
          showing = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d, logic [2:0] n, logic lr, logic al);
    din = d; shamt = n; LR = lr; AL = al; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        din = 8'($urandom); shamt = 3'($urandom); LR = 1'($urandom); AL = 1'($urandom);
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(string name, logic [7:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check(name, 32'(dout), 32'(exp));
        return;
      end
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    send(8'h96, 3'd3, DIR_LEFT, FILL_LOGIC);
    wait_out("left3", 8'hB0);
    @(negedge clk);
    check("valid_one_cycle", 32'(out_valid), 32'd0);

    send(8'h96, 3'd2, DIR_RIGHT, FILL_LOGIC);
    wait_out("right2_logic", 8'h25);
    send(8'h96, 3'd2, DIR_RIGHT, FILL_ARITH);
    wait_out("right2_arith", 8'hE5);
    send(8'h96, 3'd3, DIR_LEFT, FILL_ARITH);
    wait_out("left3_al_ignored", 8'hB0);
    send(8'h5A, 3'd0, DIR_LEFT, FILL_ARITH);
    wait_out("shamt0", 8'h5A);
    tick();

    // Backpressure: result must hold and nothing new may be accepted.
    out_ready = 1'b0;
    send(8'h80, 3'd7, DIR_RIGHT, FILL_ARITH);
    wait_out("right7_arith", 8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      din = 8'($urandom);
      in_valid = ~in_valid;
      @(negedge clk);
      check("bp_dout", 32'(dout), 32'hFF);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Asynchronous abort in the middle of a shift.
    send(8'hC3, 3'd6, DIR_LEFT, FILL_LOGIC);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    showing = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h3C, 3'd1, DIR_RIGHT, FILL_ARITH);
    wait_out("after_abort", 8'h1E);
    tick();

    // Randomized traffic with random backpressure.
    begin
      int target;
      int budget;
      target = n_acc + 1000;
      budget = 0;
      while (n_acc < target && budget < 40000) begin
        tick();
        in_valid  = ($urandom_range(0, 3) != 0);
        din       = 8'($urandom);
        shamt     = 3'($urandom);
        LR        = 1'($urandom);
        AL        = 1'($urandom);
        out_ready = 1'($urandom);
        budget++;
      end
      check("random_budget", 32'(n_acc >= target), 32'd1);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      budget = 0;
      while (sb.size() != 0 && budget < 50) begin
        tick();
        budget++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
